// File: rtl/sprite_layer_mapper.sv
// sprite_layer_mapper: double-buffered sprite attribute table, priority hit test,
// sprite-sheet ROM addressing and colour-keyed RGB output with fixed 2+ROM_LAT latency.
module sprite_layer_mapper #(
  parameter int NUM_SPRITES = 4,
  parameter int FRAME_W = 32,
  parameter int FRAME_H = 52,
  parameter int SHEET_COLS = 4,
  parameter int SHEET_ROWS = 4,
  parameter int SHEET_W = 128,
  parameter int ADDR_W = 15,
  parameter int ROM_LAT = 1,
  parameter int COORD_W = 11,
  parameter logic [31:0] KEY = 32'h00FF0000,
  localparam int IW = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1,
  localparam int FRW = SHEET_COLS * SHEET_ROWS > 1 ? $clog2(SHEET_COLS * SHEET_ROWS) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               pix_valid,
  input  logic               frame_start,
  input  logic               attr_we,
  input  logic [IW-1:0]      attr_idx,
  input  logic [COORD_W-1:0] attr_x,
  input  logic [COORD_W-1:0] attr_y,
  input  logic [FRW-1:0]     attr_frame,
  input  logic               attr_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [31:0]        rom_data,
  output logic [7:0]         Red,
  output logic [7:0]         Green,
  output logic [7:0]         Blue,
  output logic               pix_valid_out,
  output logic               sprite_hit,
  output logic [IW-1:0]      sprite_id
);
  localparam int CW = COORD_W + 1;
  localparam int SBW = 2 + IW + 7;
  localparam logic [31:0] SC = SHEET_COLS, FH = FRAME_H, FW = FRAME_W, SW = SHEET_W;
  logic [COORD_W-1:0] pend_x [NUM_SPRITES], pend_y [NUM_SPRITES], act_x [NUM_SPRITES], act_y [NUM_SPRITES];
  logic [FRW-1:0] pend_f [NUM_SPRITES], act_f [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] pend_e, act_e, hits;
  logic wr, hit0, dv, dh, opaque;
  logic [IW-1:0] id0, did;
  logic [CW-1:0] dxz, dyz;
  logic [31:0] dx, dy, fr, fc;
  logic [ADDR_W-1:0] addr0;
  logic [6:0] dxh;
  logic [SBW-1:0] s1, dl [ROM_LAT];
  assign wr = attr_we && 32'(attr_idx) < NUM_SPRITES;
  assign dxz = CW'(DrawX);
  assign dyz = CW'(DrawY);
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pend_x[i] <= '0;
        pend_y[i] <= '0;
        pend_f[i] <= '0;
        pend_e[i] <= 1'b0;
        act_x[i] <= '0;
        act_y[i] <= '0;
        act_f[i] <= '0;
        act_e[i] <= 1'b0;
      end
    end else begin
      if (wr) begin
        pend_x[attr_idx] <= attr_x;
        pend_y[attr_idx] <= attr_y;
        pend_f[attr_idx] <= attr_frame;
        pend_e[attr_idx] <= attr_en;
      end
      // a write landing on the commit edge is folded straight into the active bank
      if (frame_start)
        for (int i = 0; i < NUM_SPRITES; i++) begin
          act_x[i] <= (wr && 32'(attr_idx) == i) ? attr_x : pend_x[i];
          act_y[i] <= (wr && 32'(attr_idx) == i) ? attr_y : pend_y[i];
          act_f[i] <= (wr && 32'(attr_idx) == i) ? attr_frame : pend_f[i];
          act_e[i] <= (wr && 32'(attr_idx) == i) ? attr_en : pend_e[i];
        end
    end
  always_comb begin
    hit0 = 1'b0;
    id0 = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      hits[i] = act_e[i] && dxz >= CW'(act_x[i]) && dxz < CW'(act_x[i]) + CW'(FRAME_W)
                && dyz >= CW'(act_y[i]) && dyz < CW'(act_y[i]) + CW'(FRAME_H);
      if (hits[i]) begin
        hit0 = 1'b1;
        id0 = IW'(i);
      end
    end
    hit0 = hit0 && pix_valid;
  end
  always_comb begin
    dx = 32'(dxz - CW'(act_x[id0]));
    dy = 32'(dyz - CW'(act_y[id0]));
    fr = 32'(act_f[id0]) / SC;
    fc = 32'(act_f[id0]) % SC;
    addr0 = hit0 ? ADDR_W'((fr * FH + dy) * SW + fc * FW + dx) : '0;
  end
  assign {dv, dh, did, dxh} = dl[ROM_LAT-1];
  assign opaque = dh && rom_data != KEY;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      rom_addr <= '0;
      s1 <= '0;
      for (int k = 0; k < ROM_LAT; k++) dl[k] <= '0;
      Red <= '0;
      Green <= '0;
      Blue <= '0;
      pix_valid_out <= 1'b0;
      sprite_hit <= 1'b0;
      sprite_id <= '0;
    end else begin
      rom_addr <= addr0;
      s1 <= {pix_valid, hit0, id0, DrawX[9:3]};
      dl[0] <= s1;
      for (int k = 1; k < ROM_LAT; k++) dl[k] <= dl[k-1];
      Red <= opaque ? rom_data[23:16] : 8'h3F;
      Green <= opaque ? rom_data[15:8] : 8'h00;
      Blue <= opaque ? rom_data[7:0] : 8'h3F - {1'b0, dxh};
      pix_valid_out <= dv;
      sprite_hit <= opaque;
      sprite_id <= opaque ? did : '0;
    end
endmodule

// File: tb/tb_sprite_layer_mapper.sv
// tb_sprite_layer_mapper: randomized and directed checks of sprite_layer_mapper
// against a cycle-level reference model of the attribute table, hit test and colour rules.
module tb_sprite_layer_mapper;
  localparam logic [31:0] KEY = 32'h00FF0000;
  typedef struct packed {logic v, h; logic [1:0] id; logic [7:0] r, g, b;} exp_t;
  logic Clk = 0, Reset_n = 1;
  logic [9:0] DrawX = 0, DrawY = 0;
  logic pix_valid = 0, frame_start = 0, attr_we = 0, attr_en = 0;
  logic [1:0] attr_idx = 0;
  logic [10:0] attr_x = 0, attr_y = 0;
  logic [3:0] attr_frame = 0;
  logic [14:0] rom_addr;
  logic [31:0] rom_data;
  logic [7:0] Red, Green, Blue;
  logic pix_valid_out, sprite_hit;
  logic [1:0] sprite_id;
  exp_t got, want;
  int want_addr;
  int pend_x[4], pend_y[4], pend_f[4], act_x[4], act_y[4], act_f[4];
  bit pend_e[4], act_e[4];
  exp_t pipe[3];
  int key_addr = -1;
  bit key_mode = 0;
  int n_chk = 0, n_fail = 0;

  sprite_layer_mapper dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .pix_valid(pix_valid),
    .frame_start(frame_start), .attr_we(attr_we), .attr_idx(attr_idx), .attr_x(attr_x),
    .attr_y(attr_y), .attr_frame(attr_frame), .attr_en(attr_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .Red(Red), .Green(Green), .Blue(Blue), .pix_valid_out(pix_valid_out),
    .sprite_hit(sprite_hit), .sprite_id(sprite_id)
  );

  always #5 Clk = ~Clk;
  assign got = {pix_valid_out, sprite_hit, sprite_id, Red, Green, Blue};

  function automatic logic [31:0] texel(int a);
    logic [14:0] w = 15'(a);
    if (a == key_addr || (key_mode && a % 5 == 0)) return KEY;
    return {8'h00, w[7:0] ^ 8'hA5, 1'b1, w[14:8], w[7:0]};
  endfunction

  // synchronous sheet ROM, one cycle latency
  always @(posedge Clk) rom_data <= texel(int'(rom_addr));

  task automatic reset_model();
    for (int i = 0; i < 4; i++) begin
      pend_x[i] = 0; pend_y[i] = 0; pend_f[i] = 0; pend_e[i] = 0;
      act_x[i] = 0; act_y[i] = 0; act_f[i] = 0; act_e[i] = 0;
    end
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, h: 0, id: 0, r: 8'h3F, g: 8'h00, b: 8'h3F};
  endtask

  // predicts the current pixel, advances one clock and the model's table/pipeline
  task automatic cyc();
    int w = -1, x = int'(DrawX), y = int'(DrawY), a = 0;
    logic [31:0] t;
    exp_t e;
    for (int i = 3; i >= 0; i--)
      if (act_e[i] && x >= act_x[i] && x < act_x[i] + 32 && y >= act_y[i] && y < act_y[i] + 52) w = i;
    if (!pix_valid) w = -1;
    if (w >= 0) a = ((act_f[w] / 4 * 52 + y - act_y[w]) * 128 + act_f[w] % 4 * 32 + x - act_x[w]) % 32768;
    t = texel(a);
    e.v = pix_valid;
    if (w >= 0 && t != KEY) begin
      e.h = 1; e.id = 2'(w); {e.r, e.g, e.b} = t[23:0];
    end else begin
      e.h = 0; e.id = 0; e.r = 8'h3F; e.g = 8'h00; e.b = 8'(63 - x / 8);
    end
    @(posedge Clk);
    if (attr_we) begin
      pend_x[attr_idx] = int'(attr_x); pend_y[attr_idx] = int'(attr_y);
      pend_f[attr_idx] = int'(attr_frame); pend_e[attr_idx] = attr_en;
    end
    if (frame_start)
      for (int i = 0; i < 4; i++) begin
        act_x[i] = pend_x[i]; act_y[i] = pend_y[i]; act_f[i] = pend_f[i]; act_e[i] = pend_e[i];
      end
    pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = e;
    want = pipe[2];
    want_addr = a;
    #1;
    attr_we = 0;
    frame_start = 0;
  endtask

  task automatic wr_attr(input int idx, x, y, f, input bit en, input bit fs);
    attr_we = 1; attr_idx = 2'(idx); attr_x = 11'(x); attr_y = 11'(y);
    attr_frame = 4'(f); attr_en = en; frame_start = fs;
  endtask

  task automatic test_reset();
    #1 Reset_n = 0;
    #2;
    n_chk++;
    if ({got, rom_addr} !== '0) begin
      n_fail++; $display("FAIL reset_state got=%h/%h want=0", got, rom_addr);
    end
    reset_model();
    @(negedge Clk) Reset_n = 1;
    DrawX = 0; DrawY = 0; pix_valid = 1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      pix_valid = 0;
      n_chk += 2;
      if (got !== want) begin n_fail++; $display("FAIL reset_out k=%0d got=%h want=%h", k, got, want); end
      if (rom_addr !== 15'(want_addr)) begin n_fail++; $display("FAIL reset_addr got=%0d want=%0d", rom_addr, want_addr); end
      if (k == 2) begin
        n_chk++;
        if ({pix_valid_out, Red, Green, Blue} !== {1'b1, 24'h3F003F}) begin
          n_fail++; $display("FAIL reset_first_pixel got=%h want=13f003f", {pix_valid_out, Red, Green, Blue});
        end
      end
    end
  endtask

  task automatic test_single();
    wr_attr(0, 100, 50, 5, 1, 0);
    cyc();
    frame_start = 1;
    cyc();
    DrawX = 110; DrawY = 60; pix_valid = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) begin
        n_chk++;
        if (rom_addr !== 15'd7978) begin n_fail++; $display("FAIL single_addr got=%0d want=7978", rom_addr); end
      end
      pix_valid = 0;
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL single_out k=%0d got=%h want=%h", k, got, want); end
    end
  endtask

  task automatic test_double_buffer();
    wr_attr(1, 200, 100, 2, 1, 0);
    cyc();
    for (int k = 0; k < 11; k++) begin
      DrawX = 10'(205 + k); DrawY = 105; pix_valid = k < 8;
      frame_start = k == 3;
      cyc();
      n_chk += 2;
      if (got !== want) begin n_fail++; $display("FAIL dbuf_out k=%0d got=%h want=%h", k, got, want); end
      if (rom_addr !== 15'(want_addr)) begin n_fail++; $display("FAIL dbuf_addr got=%0d want=%0d", rom_addr, want_addr); end
    end
  endtask

  task automatic test_priority_key();
    int px[6] = '{110, 135, 0, 110, 0, 0};
    bit pv[6] = '{1, 1, 0, 0, 0, 0};
    wr_attr(2, 105, 55, 3, 1, 1);
    cyc();
    key_addr = 7978;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 6; k++) begin
        DrawX = 10'(px[k]); DrawY = 60; pix_valid = pv[k];
        cyc();
        n_chk++;
        if (got !== want) begin n_fail++; $display("FAIL prio r=%0d k=%0d got=%h want=%h", r, k, got, want); end
      end
      key_addr = -1;
    end
  endtask

  task automatic test_boundaries();
    int px[11] = '{0, 639, 1023, 299, 300, 331, 332, 310, 310, 0, 0};
    int py[11] = '{0, 10, 0, 205, 205, 251, 205, 251, 252, 0, 0};
    wr_attr(3, 2040, 0, 0, 1, 1);
    cyc();
    wr_attr(1, 300, 200, 7, 1, 1);
    cyc();
    for (int k = 0; k < 11; k++) begin
      DrawX = 10'(px[k]); DrawY = 10'(py[k]); pix_valid = k < 9;
      cyc();
      n_chk += 2;
      if (got !== want) begin n_fail++; $display("FAIL bound k=%0d got=%h want=%h", k, got, want); end
      if (rom_addr !== 15'(want_addr)) begin n_fail++; $display("FAIL bound_addr got=%0d want=%0d", rom_addr, want_addr); end
      if (k == 3) begin
        n_chk++;
        if (Blue !== 8'hF0) begin n_fail++; $display("FAIL bound_blue639 got=%h want=f0", Blue); end
      end
    end
  endtask

  task automatic test_random();
    key_mode = 1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom % 4 == 0)
        wr_attr($urandom_range(0, 3), ($urandom % 10 == 0) ? $urandom_range(2030, 2047) : $urandom_range(50, 230),
                $urandom_range(0, 160), $urandom_range(0, 15), $urandom % 4 != 0, 0);
      frame_start = $urandom % 8 == 0;
      DrawX = 10'(($urandom % 4 == 0) ? $urandom_range(0, 1023) : $urandom_range(60, 260));
      DrawY = 10'($urandom_range(0, 200));
      pix_valid = k < 396 && $urandom % 4 != 0;
      cyc();
      n_chk += 2;
      if (got !== want) begin n_fail++; $display("FAIL rand k=%0d got=%h want=%h", k, got, want); end
      if (rom_addr !== 15'(want_addr)) begin n_fail++; $display("FAIL rand_addr k=%0d got=%0d want=%0d", k, rom_addr, want_addr); end
    end
    key_mode = 0;
  endtask

  task automatic test_reset_mid();
    wr_attr(0, 100, 50, 5, 1, 1);
    cyc();
    DrawY = 60; pix_valid = 1;
    for (int k = 0; k < 3; k++) begin
      DrawX = 10'(105 + k);
      cyc();
    end
    #2 Reset_n = 0;
    #1;
    n_chk++;
    if ({got, rom_addr} !== '0) begin n_fail++; $display("FAIL midreset_async got=%h/%h want=0", got, rom_addr); end
    reset_model();
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1;
    pix_valid = 0;
    for (int k = 0; k < 8; k++) begin
      DrawX = 10'(110 + k); pix_valid = k >= 3 && k < 5;
      cyc();
      n_chk += 2;
      if (got !== want) begin n_fail++; $display("FAIL midreset_out k=%0d got=%h want=%h", k, got, want); end
      if (rom_addr !== 15'(want_addr)) begin n_fail++; $display("FAIL midreset_addr got=%0d want=%0d", rom_addr, want_addr); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_double_buffer();
    test_priority_key();
    test_boundaries();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
